// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA pixel-timing generator: clock divider, h/v counters, phase FSMs and registered sync/DE/coordinate outputs.
// Define VGA_SYNC_POS_EN for active-high hsync/vsync (default is active-low).
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_pix_stb,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_de,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_line,
  output logic       o_frame
);

`ifdef VGA_SYNC_POS_EN
  localparam logic SYNC_ON = 1'b1;
`else
  localparam logic SYNC_ON = 1'b0;
`endif

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [9:0] H_FRONT = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNCS = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BACK  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_FRONT = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNCS = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BACK  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

  logic [DW-1:0] div, div_n;
  logic [9:0]    h, h_n, v, v_n;
  logic          h_wrap;
  phase_t        h_ph, h_ph_n, v_ph, v_ph_n;
  logic          hs_d, vs_d, de_d;

  always_comb begin
    div_n  = (div == DIV_LAST) ? '0 : div + 1'b1;
    h_wrap = (h == H_LAST);
    h_n    = h_wrap ? '0 : h + 10'd1;
    v_n    = v;
    if (h_wrap) v_n = (v == V_LAST) ? '0 : v + 10'd1;
  end

  // Strobe is registered from the next divider value so it is high while div == CLK_DIV-1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div       <= '0;
      o_pix_stb <= 1'b0;
    end else begin
      div       <= div_n;
      o_pix_stb <= (div_n == DIV_LAST);
    end
  end

  // Counters and phase state registers; reset parks at the last pixel so the first strobe lands on (0,0).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h    <= H_LAST;
      v    <= V_LAST;
      h_ph <= PH_BACK;
      v_ph <= PH_BACK;
    end else if (o_pix_stb) begin
      h    <= h_n;
      v    <= v_n;
      h_ph <= h_ph_n;
      v_ph <= v_ph_n;
    end
  end

  always_comb begin
    h_ph_n = h_ph;
    case (h_ph)
      PH_ACTIVE: if (h_n == H_FRONT) h_ph_n = PH_FRONT;
      PH_FRONT:  if (h_n == H_SYNCS) h_ph_n = PH_SYNC;
      PH_SYNC:   if (h_n == H_BACK)  h_ph_n = PH_BACK;
      PH_BACK:   if (h_n == '0)      h_ph_n = PH_ACTIVE;
      default:   h_ph_n = PH_BACK;
    endcase
    v_ph_n = v_ph;
    if (h_wrap) begin
      case (v_ph)
        PH_ACTIVE: if (v_n == V_FRONT) v_ph_n = PH_FRONT;
        PH_FRONT:  if (v_n == V_SYNCS) v_ph_n = PH_SYNC;
        PH_SYNC:   if (v_n == V_BACK)  v_ph_n = PH_BACK;
        PH_BACK:   if (v_n == '0)      v_ph_n = PH_ACTIVE;
        default:   v_ph_n = PH_BACK;
      endcase
    end
  end

  always_comb begin
    hs_d = (h_ph_n == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
    vs_d = (v_ph_n == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
    de_d = (h_ph_n == PH_ACTIVE) && (v_ph_n == PH_ACTIVE);
  end

  // Outputs move only on the strobe edge; line/frame pulses drop on the following edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_hs    <= ~SYNC_ON;
      o_vs    <= ~SYNC_ON;
      o_de    <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_line  <= 1'b0;
      o_frame <= 1'b0;
    end else if (o_pix_stb) begin
      o_hs    <= hs_d;
      o_vs    <= vs_d;
      o_de    <= de_d;
      o_x     <= de_d ? h_n : '0;
      o_y     <= de_d ? v_n[8:0] : '0;
      o_line  <= h_wrap;
      o_frame <= h_wrap && (v == V_LAST);
    end else begin
      o_line  <= 1'b0;
      o_frame <= 1'b0;
    end
  end

endmodule
